id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage.sv | 141 ++++++++++++++
 tb/tb_id_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// rtl/id_stage.sv - decode stage: IF/ID register, 8x16 regfile with bypass, operand forwarding, compare/targets, ID/EX register
module id_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] if_instr,
    input  logic [15:0] if_npc,
    input  logic        stall,
    input  logic        kill,
    input  logic [15:0] ctrl_in,
    input  logic [1:0]  forward_a,
    input  logic [1:0]  forward_b,
    input  logic [15:0] ex_fwd_data,
    input  logic [15:0] mem_fwd_data,
    input  logic        wb_we,
    input  logic [2:0]  wb_rd,
    input  logic [15:0] wb_data,
    output logic [15:0] id_instr,
    output logic [15:0] id_npc,
    output logic        gt,
    output logic        lt,
    output logic        eq,
    output logic [15:0] i_target,
    output logic [15:0] j_target,
    output logic [15:0] ret_addr,
    output logic        ex_valid,
    output logic [15:0] ex_ctrl,
    output logic [15:0] ex_a,
    output logic [15:0] ex_b,
    output logic [15:0] ex_imm,
    output logic [2:0]  ex_rd,
    output logic [15:0] ex_npc
);

    logic [15:0] instr_q, instr_d;
    logic [15:0] npc_q, npc_d;
    logic [15:0] rf_q [0:7];

    logic        ex_valid_q;
    logic [15:0] ex_ctrl_q, ex_a_q, ex_b_q, ex_imm_q, ex_npc_q;
    logic [2:0]  ex_rd_q;

    logic [2:0]  rs1, rs2;
    logic [5:0]  imm6;
    logic [15:0] imm_sext, imm_zext;
    logic [15:0] rd1, rd2;
    logic [15:0] opa, opb;

    assign rs1      = instr_q[8:6];
    assign rs2      = instr_q[5:3];
    assign imm6     = instr_q[5:0];
    assign imm_sext = {{10{imm6[5]}}, imm6};
    assign imm_zext = {10'd0, imm6};

    // Same-cycle write-back is visible to the read; R0 always reads zero.
    always_comb begin
        rd1 = 16'h0000;
        rd2 = 16'h0000;
        if (rs1 != 3'd0) rd1 = (wb_we && wb_rd == rs1) ? wb_data : rf_q[rs1];
        if (rs2 != 3'd0) rd2 = (wb_we && wb_rd == rs2) ? wb_data : rf_q[rs2];
    end

    always_comb begin
        opa = rd1;
        case (forward_a)
            2'b01:   opa = ex_fwd_data;
            2'b10:   opa = mem_fwd_data;
            2'b11:   opa = wb_data;
            default: opa = rd1;
        endcase
        opb = rd2;
        case (forward_b)
            2'b01:   opb = ex_fwd_data;
            2'b10:   opb = mem_fwd_data;
            2'b11:   opb = wb_data;
            default: opb = rd2;
        endcase
    end

    always_comb begin
        instr_d = instr_q;
        npc_d   = npc_q;
        if (!stall) begin
            instr_d = kill ? 16'h0000 : if_instr;
            npc_d   = if_npc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q    <= 16'h0000;
            npc_q      <= 16'h0000;
            for (int i = 0; i < 8; i++) rf_q[i] <= 16'h0000;
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= 16'h0000;
            ex_a_q     <= 16'h0000;
            ex_b_q     <= 16'h0000;
            ex_imm_q   <= 16'h0000;
            ex_rd_q    <= 3'd0;
            ex_npc_q   <= 16'h0000;
        end else begin
            instr_q <= instr_d;
            npc_q   <= npc_d;
            if (wb_we && wb_rd != 3'd0) rf_q[wb_rd] <= wb_data;
            if (stall) begin
                ex_valid_q <= 1'b0;
                ex_ctrl_q  <= 16'h0000;
                ex_a_q     <= 16'h0000;
                ex_b_q     <= 16'h0000;
                ex_imm_q   <= 16'h0000;
                ex_rd_q    <= 3'd0;
                ex_npc_q   <= 16'h0000;
            end else begin
                ex_valid_q <= 1'b1;
                ex_ctrl_q  <= ctrl_in;
                ex_a_q     <= opa;
                ex_b_q     <= opb;
                ex_imm_q   <= ctrl_in[15] ? imm_zext : imm_sext;
                ex_rd_q    <= instr_q[11:9];
                ex_npc_q   <= npc_q;
            end
        end
    end

    assign id_instr = instr_q;
    assign id_npc   = npc_q;
    assign gt       = $signed(opa) > $signed(opb);
    assign lt       = $signed(opa) < $signed(opb);
    assign eq       = (opa == opb);
    assign i_target = npc_q + imm_sext;
    assign j_target = {npc_q[15:12], instr_q[11:0]};
    assign ret_addr = opa;

    assign ex_valid = ex_valid_q;
    assign ex_ctrl  = ex_ctrl_q;
    assign ex_a     = ex_a_q;
    assign ex_b     = ex_b_q;
    assign ex_imm   = ex_imm_q;
    assign ex_rd    = ex_rd_q;
    assign ex_npc   = ex_npc_q;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed plus randomized checks of id_stage against a behavioural model
module tb_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] if_instr, if_npc, ctrl_in;
    logic        stall, kill;
    logic [1:0]  forward_a, forward_b;
    logic [15:0] ex_fwd_data, mem_fwd_data, wb_data;
    logic        wb_we;
    logic [2:0]  wb_rd;
    logic [15:0] id_instr, id_npc, i_target, j_target, ret_addr;
    logic        gt, lt, eq, ex_valid;
    logic [15:0] ex_ctrl, ex_a, ex_b, ex_imm, ex_npc;
    logic [2:0]  ex_rd;

    int tests = 0;
    int fails = 0;

    // Model state: architectural view of the pipeline registers and regfile
    logic [15:0] m_instr, m_npc;
    logic [15:0] m_rf [8];
    logic        m_valid;
    logic [15:0] m_ctrl, m_a, m_b, m_imm, m_npc_ex;
    logic [2:0]  m_rd;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .reset(reset), .if_instr(if_instr), .if_npc(if_npc),
        .stall(stall), .kill(kill), .ctrl_in(ctrl_in),
        .forward_a(forward_a), .forward_b(forward_b),
        .ex_fwd_data(ex_fwd_data), .mem_fwd_data(mem_fwd_data),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .id_instr(id_instr), .id_npc(id_npc), .gt(gt), .lt(lt), .eq(eq),
        .i_target(i_target), .j_target(j_target), .ret_addr(ret_addr),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_a(ex_a), .ex_b(ex_b),
        .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_npc(ex_npc)
    );

    function automatic logic [15:0] rf_read(input logic [2:0] r);
        if (r == 0) return 16'h0000;
        if (wb_we && wb_rd == r) return wb_data;
        return m_rf[r];
    endfunction

    function automatic logic [15:0] operand(input logic [1:0] sel, input logic [2:0] r);
        if (sel == 1) return ex_fwd_data;
        if (sel == 2) return mem_fwd_data;
        if (sel == 3) return wb_data;
        return rf_read(r);
    endfunction

    function automatic logic [15:0] sext6(input logic [5:0] v);
        int s;
        s = (v >= 32) ? int'(v) - 64 : int'(v);
        return 16'(s);
    endfunction

    function automatic logic [15:0] mod_a();
        return operand(forward_a, m_instr[8:6]);
    endfunction

    function automatic logic [15:0] mod_b();
        return operand(forward_b, m_instr[5:3]);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [15:0] a, b;
        int sa, sb;
        a = mod_a();
        b = mod_b();
        sa = int'($signed(a));
        sb = int'($signed(b));
        chk("id_instr", id_instr, m_instr);
        chk("id_npc", id_npc, m_npc);
        chk("gt", 16'(gt), 16'(sa > sb));
        chk("lt", 16'(lt), 16'(sa < sb));
        chk("eq", 16'(eq), 16'(sa == sb));
        chk("i_target", i_target, 16'(m_npc + sext6(m_instr[5:0])));
        chk("j_target", j_target, (m_npc & 16'hF000) | (m_instr & 16'h0FFF));
        chk("ret_addr", ret_addr, a);
        chk("ex_valid", 16'(ex_valid), 16'(m_valid));
        chk("ex_ctrl", ex_ctrl, m_ctrl);
        chk("ex_a", ex_a, m_a);
        chk("ex_b", ex_b, m_b);
        chk("ex_imm", ex_imm, m_imm);
        chk("ex_rd", 16'(ex_rd), 16'(m_rd));
        chk("ex_npc", ex_npc, m_npc_ex);
    endtask

    // Advance one clock, applying the model's next-state rules to the pre-edge inputs
    task automatic tick();
        logic [15:0] a, b;
        a = mod_a();
        b = mod_b();
        @(posedge clk);
        if (reset) begin
            m_instr = 0; m_npc = 0;
            for (int i = 0; i < 8; i++) m_rf[i] = 0;
            m_valid = 0; m_ctrl = 0; m_a = 0; m_b = 0; m_imm = 0; m_rd = 0; m_npc_ex = 0;
        end else begin
            if (stall) begin
                m_valid = 0; m_ctrl = 0; m_a = 0; m_b = 0; m_imm = 0; m_rd = 0; m_npc_ex = 0;
            end else begin
                m_valid = 1; m_ctrl = ctrl_in; m_a = a; m_b = b;
                m_imm = ctrl_in[15] ? {10'd0, m_instr[5:0]} : sext6(m_instr[5:0]);
                m_rd = m_instr[11:9]; m_npc_ex = m_npc;
                m_instr = kill ? 16'h0000 : if_instr;
                m_npc = if_npc;
            end
            if (wb_we && wb_rd != 0) m_rf[wb_rd] = wb_data;
        end
        #1;
    endtask

    initial begin
        reset = 1; if_instr = 0; if_npc = 0; stall = 0; kill = 0; ctrl_in = 0;
        forward_a = 0; forward_b = 0; ex_fwd_data = 0; mem_fwd_data = 0;
        wb_we = 1; wb_rd = 3'd4; wb_data = 16'h7777;
        for (int i = 0; i < 8; i++) m_rf[i] = 16'hXXXX;
        tick(); tick();
        wb_we = 0;
        #1;
        chk("rst_id_instr", id_instr, 16'h0000);
        chk("rst_ex_valid", 16'(ex_valid), 16'h0000);
        chk("rst_eq", 16'(eq), 16'h0001);
        chk("rst_gt_lt", 16'({gt, lt}), 16'h0000);
        check_model();
        reset = 0;

        wb_we = 1; wb_rd = 3; wb_data = 16'h1234; tick();
        wb_we = 0; if_instr = 16'h00C0; if_npc = 16'h0001; tick();
        tick();
        chk("r3_ex_a", ex_a, 16'h1234);
        check_model();

        if_instr = 16'h0080; tick();
        wb_we = 1; wb_rd = 2; wb_data = 16'hBEEF; #1;
        chk("bypass_a", ret_addr, 16'hBEEF);
        tick();
        if_instr = 16'h0000; tick();
        wb_we = 1; wb_rd = 0; wb_data = 16'h5555; #1;
        chk("r0_a", ret_addr, 16'h0000);
        tick(); wb_we = 0;

        forward_a = 2'b01; ex_fwd_data = 16'hFFFF; forward_b = 2'b10; mem_fwd_data = 16'h0001; #1;
        chk("signed_lt", 16'({gt, lt, eq}), 16'b010);
        check_model();
        forward_a = 0; forward_b = 0;

        if_instr = 16'h1234; tick();
        stall = 1; if_instr = 16'h9999; tick();
        chk("stall1_instr", id_instr, 16'h1234);
        chk("stall1_valid", 16'(ex_valid), 16'h0000);
        tick();
        chk("stall2_instr", id_instr, 16'h1234);
        chk("stall2_valid", 16'(ex_valid), 16'h0000);
        stall = 0; if_instr = 16'h5678; tick();
        chk("resume_instr", id_instr, 16'h5678);
        chk("resume_valid", 16'(ex_valid), 16'h0001);

        kill = 1; if_npc = 16'h0042; tick();
        chk("kill_instr", id_instr, 16'h0000);
        chk("kill_npc", id_npc, 16'h0042);
        kill = 0; if_instr = 16'h4321; tick();
        kill = 1; stall = 1; if_instr = 16'h1111; tick();
        chk("killstall_instr", id_instr, 16'h4321);
        chk("killstall_valid", 16'(ex_valid), 16'h0000);
        kill = 0; stall = 0;

        if_instr = 16'h003E; if_npc = 16'h0010; tick();
        chk("itgt_back", i_target, 16'h000E);
        if_instr = 16'h0001; if_npc = 16'hFFFF; tick();
        chk("itgt_wrap", i_target, 16'h0000);

        reset = 1; wb_we = 1; wb_rd = 5; wb_data = 16'hAAAA; tick();
        reset = 0; wb_we = 0; if_instr = 16'h0140; tick();
        chk("rst_no_wb", ret_addr, 16'h0000);
        check_model();

        for (int n = 0; n < 400; n++) begin
            reset        = ($urandom_range(0, 49) == 0);
            stall        = ($urandom_range(0, 5) == 0);
            kill         = ($urandom_range(0, 5) == 0);
            if_instr     = 16'($urandom);
            if_npc       = 16'($urandom);
            ctrl_in      = 16'($urandom);
            forward_a    = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom);
            forward_b    = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom);
            ex_fwd_data  = 16'($urandom);
            mem_fwd_data = 16'($urandom);
            wb_we        = 1'($urandom);
            wb_rd        = 3'($urandom);
            wb_data      = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
            #1;
            check_model();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
